// File: rtl/reservation_alu3_issue.sv
// Issue/control stage for the four-entry ALU3 reservation station: allocates
// free entries, keeps age order, issues the oldest ready entry into an output register.
module reservation_alu3_issue (
  input  logic          iCLOCK,
  input  logic          iRESET_SYNC,
  input  logic          iFLUSH,
  input  logic          iDISPATCH_VALID,
  output logic          oDISPATCH_LOCK,
  output logic [3:0]    oREGIST_VALID,
  output logic          oREMOVE_VALID,
  output logic [3:0]    oEXOUT_VALID,
  input  logic [3:0]    iENTRY_MATCHING,
  input  logic [19:0]   iENTRY_CMD,
  input  logic [127:0]  iENTRY_SOURCE0,
  input  logic [127:0]  iENTRY_SOURCE1,
  input  logic [23:0]   iENTRY_DESTINATION_REGNAME,
  input  logic [3:0]    iENTRY_DESTINATION_SYSREG,
  input  logic [23:0]   iENTRY_COMMIT_TAG,
  input  logic [127:0]  iENTRY_PC,
  output logic          oEX_VALID,
  input  logic          iEX_LOCK,
  output logic [4:0]    oEX_CMD,
  output logic [31:0]   oEX_SOURCE0,
  output logic [31:0]   oEX_SOURCE1,
  output logic [5:0]    oEX_DESTINATION_REGNAME,
  output logic          oEX_DESTINATION_SYSREG,
  output logic [5:0]    oEX_COMMIT_TAG,
  output logic [31:0]   oEX_PC
);

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CMD_W   = 5;
  localparam int unsigned REG_W   = 6;
  localparam int unsigned TAG_W   = 6;

  logic [ENTRIES-1:0] r_occ;
  logic [IDX_W-1:0]   r_queue [ENTRIES];
  logic [CNT_W-1:0]   r_count;
  logic               r_ex_valid;
  logic [CMD_W-1:0]   r_ex_cmd;
  logic [DATA_W-1:0]  r_ex_src0;
  logic [DATA_W-1:0]  r_ex_src1;
  logic [REG_W-1:0]   r_ex_dest;
  logic               r_ex_sysreg;
  logic [TAG_W-1:0]   r_ex_tag;
  logic [DATA_W-1:0]  r_ex_pc;

  logic               w_clear;
  logic               w_full;
  logic               w_alloc;
  logic [IDX_W-1:0]   w_target;
  logic               w_can_issue;
  logic               w_found;
  logic [IDX_W-1:0]   w_slot;
  logic [IDX_W-1:0]   w_cand;
  logic               w_issue;
  logic [CNT_W-1:0]   w_count_dec;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ENTRIES-1:0] w_occ_nxt;
  logic [IDX_W-1:0]   w_queue_nxt [ENTRIES];

  // Allocation target and oldest-ready candidate selection
  always_comb begin
    w_clear     = iFLUSH | iRESET_SYNC;
    w_full      = (r_count == CNT_W'(ENTRIES));
    w_alloc     = iDISPATCH_VALID & ~w_full & ~w_clear;
    w_can_issue = (~r_ex_valid | ~iEX_LOCK) & ~w_clear;
    w_target    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_occ[i]) w_target = IDX_W'(i);
    end
    w_found = 1'b0;
    w_slot  = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if ((CNT_W'(k) < r_count) && r_occ[r_queue[k]] && iENTRY_MATCHING[r_queue[k]]) begin
        w_found = 1'b1;
        w_slot  = IDX_W'(k);
      end
    end
    w_cand  = r_queue[w_slot];
    w_issue = w_found & w_can_issue;
  end

  // Queue compaction first, then append of the new entry at the post-removal tail
  always_comb begin
    for (int k = 0; k < ENTRIES; k++) w_queue_nxt[k] = r_queue[k];
    if (w_issue) begin
      for (int k = 0; k < ENTRIES - 1; k++) begin
        if (IDX_W'(k) >= w_slot) w_queue_nxt[k] = r_queue[k+1];
      end
      w_queue_nxt[ENTRIES-1] = '0;
    end
    w_count_dec = r_count - CNT_W'(w_issue);
    if (w_alloc) w_queue_nxt[w_count_dec[IDX_W-1:0]] = w_target;
    w_count_nxt = w_count_dec + CNT_W'(w_alloc);
    w_occ_nxt   = r_occ;
    if (w_issue) w_occ_nxt[w_cand] = 1'b0;
    if (w_alloc) w_occ_nxt[w_target] = 1'b1;
  end

  always_comb begin
    oDISPATCH_LOCK = w_full;
    oREMOVE_VALID  = w_clear;
    oREGIST_VALID  = w_alloc ? (ENTRIES'(1) << w_target) : '0;
    oEXOUT_VALID   = w_issue ? (ENTRIES'(1) << w_cand) : '0;
  end

  always_ff @(posedge iCLOCK) begin
    if (w_clear) begin
      r_occ   <= '0;
      r_count <= '0;
      for (int k = 0; k < ENTRIES; k++) r_queue[k] <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_count <= w_count_nxt;
      for (int k = 0; k < ENTRIES; k++) r_queue[k] <= w_queue_nxt[k];
    end
  end

  // Output register: load on issue, drop valid once accepted, hold under lock
  always_ff @(posedge iCLOCK) begin
    if (w_clear) begin
      r_ex_valid  <= 1'b0;
      r_ex_cmd    <= '0;
      r_ex_src0   <= '0;
      r_ex_src1   <= '0;
      r_ex_dest   <= '0;
      r_ex_sysreg <= 1'b0;
      r_ex_tag    <= '0;
      r_ex_pc     <= '0;
    end else if (w_issue) begin
      r_ex_valid  <= 1'b1;
      r_ex_cmd    <= iENTRY_CMD[CMD_W*int'(w_cand) +: CMD_W];
      r_ex_src0   <= iENTRY_SOURCE0[DATA_W*int'(w_cand) +: DATA_W];
      r_ex_src1   <= iENTRY_SOURCE1[DATA_W*int'(w_cand) +: DATA_W];
      r_ex_dest   <= iENTRY_DESTINATION_REGNAME[REG_W*int'(w_cand) +: REG_W];
      r_ex_sysreg <= iENTRY_DESTINATION_SYSREG[w_cand];
      r_ex_tag    <= iENTRY_COMMIT_TAG[TAG_W*int'(w_cand) +: TAG_W];
      r_ex_pc     <= iENTRY_PC[DATA_W*int'(w_cand) +: DATA_W];
    end else if (!iEX_LOCK) begin
      r_ex_valid  <= 1'b0;
    end
  end

  assign oEX_VALID               = r_ex_valid;
  assign oEX_CMD                 = r_ex_cmd;
  assign oEX_SOURCE0             = r_ex_src0;
  assign oEX_SOURCE1             = r_ex_src1;
  assign oEX_DESTINATION_REGNAME = r_ex_dest;
  assign oEX_DESTINATION_SYSREG  = r_ex_sysreg;
  assign oEX_COMMIT_TAG          = r_ex_tag;
  assign oEX_PC                  = r_ex_pc;

endmodule

// File: tb/tb_reservation_alu3_issue.sv
// Directed bench for reservation_alu3_issue; each entry i presents a fixed payload
// (PC 0x100+4i, CMD i+1) so issued order can be read off oEX_PC.
module tb_reservation_alu3_issue;

  logic          clk = 1'b0;
  logic          rst, flush, dv, exlock;
  logic [3:0]    match;
  logic [19:0]   cmd;
  logic [127:0]  src0, src1, pc;
  logic [23:0]   dest, tag;
  logic [3:0]    sysreg;
  logic          lock_o, remove_o, ex_valid;
  logic [3:0]    regist_o, exout_o;
  logic [4:0]    ex_cmd;
  logic [31:0]   ex_src0, ex_src1, ex_pc;
  logic [5:0]    ex_dest, ex_tag;
  logic          ex_sysreg;

  int errors = 0;
  int checks = 0;

  reservation_alu3_issue dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush), .iDISPATCH_VALID(dv),
    .oDISPATCH_LOCK(lock_o), .oREGIST_VALID(regist_o), .oREMOVE_VALID(remove_o),
    .oEXOUT_VALID(exout_o), .iENTRY_MATCHING(match), .iENTRY_CMD(cmd),
    .iENTRY_SOURCE0(src0), .iENTRY_SOURCE1(src1),
    .iENTRY_DESTINATION_REGNAME(dest), .iENTRY_DESTINATION_SYSREG(sysreg),
    .iENTRY_COMMIT_TAG(tag), .iENTRY_PC(pc), .oEX_VALID(ex_valid), .iEX_LOCK(exlock),
    .oEX_CMD(ex_cmd), .oEX_SOURCE0(ex_src0), .oEX_SOURCE1(ex_src1),
    .oEX_DESTINATION_REGNAME(ex_dest), .oEX_DESTINATION_SYSREG(ex_sysreg),
    .oEX_COMMIT_TAG(ex_tag), .oEX_PC(ex_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [4];
    for (int i = 0; i < 4; i++) begin
      pc[i*32 +: 32]   = 32'h100 + 32'(4 * i);
      src0[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      src1[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      cmd[i*5 +: 5]    = 5'(i + 1);
      dest[i*6 +: 6]   = 6'(i + 10);
      tag[i*6 +: 6]    = 6'(i + 20);
      sysreg[i]        = (i == 2);
    end
    rst = 1'b1; flush = 1'b0; dv = 1'b1; exlock = 1'b0; match = 4'b0000;

    // Reset
    #2;
    check("rst_remove", 32'(remove_o), 32'd1);
    check("rst_regist", 32'(regist_o), 32'd0);
    tick();
    check("rst_exvalid", 32'(ex_valid), 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_lock", 32'(lock_o), 32'd0);
    check("rst_exout", 32'(exout_o), 32'd0);
    rst = 1'b0; dv = 1'b0;
    #1;
    check("rel_remove", 32'(remove_o), 32'd0);

    // Fill the station in order
    dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alloc", 32'(regist_o), 32'(1 << i));
      tick();
    end
    check("full_lock", 32'(lock_o), 32'd1);
    #1;
    check("full_no_alloc", 32'(regist_o), 32'd0);

    // Entries 0 and 2 ready together: oldest first, then 2 back-to-back
    dv = 1'b0; match = 4'b0101;
    #1;
    check("issue_e0", 32'(exout_o), 32'b0001);
    tick();
    check("ex_valid_e0", 32'(ex_valid), 32'd1);
    check("ex_pc_e0", ex_pc, 32'h100);
    check("ex_cmd_e0", 32'(ex_cmd), 32'd1);
    check("ex_src1_e0", ex_src1, 32'hB000_0000);
    #1;
    check("issue_e2", 32'(exout_o), 32'b0100);
    tick();
    check("ex_pc_e2", ex_pc, 32'h108);
    check("ex_sys_e2", 32'(ex_sysreg), 32'd1);
    check("ex_tag_e2", 32'(ex_tag), 32'd22);

    // Downstream lock holds the payload and blocks issue of entry 1
    exlock = 1'b1; match = 4'b0010;
    repeat (3) begin
      #1;
      check("lock_no_issue", 32'(exout_o), 32'd0);
      tick();
      check("lock_valid", 32'(ex_valid), 32'd1);
      check("lock_pc", ex_pc, 32'h108);
    end
    exlock = 1'b0;
    #1;
    check("unlock_issue_e1", 32'(exout_o), 32'b0010);
    tick();
    check("ex_pc_e1", ex_pc, 32'h104);

    // Occupy three entries with the output register held, then flush
    exlock = 1'b1; match = 4'b0000; dv = 1'b1;
    #1;
    check("refill_e0", 32'(regist_o), 32'b0001);
    tick();
    #1;
    check("refill_e1", 32'(regist_o), 32'b0010);
    tick();
    check("held_valid", 32'(ex_valid), 32'd1);
    flush = 1'b1; match = 4'b1111;
    #1;
    check("flush_remove", 32'(remove_o), 32'd1);
    check("flush_regist", 32'(regist_o), 32'd0);
    check("flush_exout", 32'(exout_o), 32'd0);
    tick();
    flush = 1'b0; dv = 1'b0; exlock = 1'b0; match = 4'b0000;
    check("flush_exvalid", 32'(ex_valid), 32'd0);
    check("flush_pc", ex_pc, 32'd0);
    check("flush_lock", 32'(lock_o), 32'd0);
    #1;
    check("flush_rel_remove", 32'(remove_o), 32'd0);

    // Refill all four from an empty station
    dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alloc2", 32'(regist_o), 32'(1 << i));
      tick();
    end

    // Issue entry 1 while full: no alloc that cycle, entry 1 re-allocated next
    match = 4'b0010;
    #1;
    check("full_issue_e1", 32'(exout_o), 32'b0010);
    check("full_issue_noalloc", 32'(regist_o), 32'd0);
    check("full_issue_lock", 32'(lock_o), 32'd1);
    tick();
    match = 4'b0000;
    check("freed_lock", 32'(lock_o), 32'd0);
    check("ex_pc_e1b", ex_pc, 32'h104);
    #1;
    check("realloc_e1", 32'(regist_o), 32'b0010);
    tick();
    dv = 1'b0;
    check("refull_lock", 32'(lock_o), 32'd1);

    // Drain: age order must be 0,2,3,1 with one issue per cycle
    order[0] = 0; order[1] = 2; order[2] = 3; order[3] = 1;
    match = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("drain_exout", 32'(exout_o), 32'(1 << order[j]));
      tick();
      check("drain_valid", 32'(ex_valid), 32'd1);
      check("drain_pc", ex_pc, 32'h100 + 32'(4 * order[j]));
    end
    match = 4'b0000;
    #1;
    check("empty_exout", 32'(exout_o), 32'd0);
    tick();
    check("accept_clear", 32'(ex_valid), 32'd0);

    // Reset mid-stream with matching entries and a valid output
    dv = 1'b1;
    #1;
    check("pre_rst_a0", 32'(regist_o), 32'b0001);
    tick();
    #1;
    check("pre_rst_a1", 32'(regist_o), 32'b0010);
    tick();
    dv = 1'b0; match = 4'b1111;
    #1;
    check("pre_rst_issue", 32'(exout_o), 32'b0001);
    tick();
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_exout", 32'(exout_o), 32'd0);
    check("mid_rst_remove", 32'(remove_o), 32'd1);
    tick();
    rst = 1'b0; match = 4'b0000;
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_pc", ex_pc, 32'd0);
    check("mid_rst_cmd", 32'(ex_cmd), 32'd0);
    check("mid_rst_lock", 32'(lock_o), 32'd0);
    dv = 1'b1;
    #1;
    check("post_rst_remove", 32'(remove_o), 32'd0);
    check("post_rst_alloc", 32'(regist_o), 32'b0001);
    tick();
    dv = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
